// File: rtl/pad_out_reg_cell_pkg.sv
// Shared definitions for the registered output pad cell: FSM encoding and
// parameter legal ranges.
package pad_reg_pkg;

   typedef enum logic [1:0] {
      ST_OFF   = 2'b00,
      ST_DRIVE = 2'b01,
      ST_TURN  = 2'b10
   } pad_state_t;

   localparam int PIPE_DEPTH_MIN = 1;
   localparam int PIPE_DEPTH_MAX = 3;
   localparam int TURN_CYC_MIN   = 0;
   localparam int TURN_CYC_MAX   = 3;

   // Counter preload on entry to TURN; zero-cycle turnaround never enters TURN.
   function automatic logic [1:0] turn_load(input int cyc);
      return (cyc > 0) ? 2'(cyc - 1) : 2'd0;
   endfunction

endpackage

// File: rtl/pad_out_reg_cell_dff.sv
// Flop primitive for the pad cell: async active-high reset, clock enable.
module pad_dff (
   input  logic D,
   output logic Q,
   input  logic CLK,
   input  logic RST,
   input  logic EN
);

   always_ff @(posedge CLK or posedge RST) begin
      if (RST)
         Q <= 1'b0;
      else if (EN)
         Q <= D;
   end

endmodule

// File: rtl/pad_out_reg_cell.sv
// Registered output pad cell: PIPE_DEPTH data pipeline plus an output-enable
// turnaround FSM whose enable is delayed to line up with the data at the pad.
//
//   state    | meaning
//   ---------+---------------------------------------------------
//   ST_OFF   | pad not driven (IQEN=0)
//   ST_DRIVE | pad driven (IQEN=1)
//   ST_TURN  | forced high-Z for TURN_CYC cycles (IQEN=0, BUSY=1)
(* whitebox *)
(* FASM_PARAMS = "OSEL=OSEL;ESEL=ESEL;PIPE_DEPTH=PIPE_DEPTH;TURN_CYC=TURN_CYC" *)
module pad_out_reg_cell
   import pad_reg_pkg::*;
#(
   parameter bit OSEL       = 1'b1,
   parameter bit ESEL       = 1'b1,
   parameter int PIPE_DEPTH = 1,
   parameter int TURN_CYC   = 1
) (
   input  logic IQC,
   input  logic QRT,
   input  logic IQE,
   input  logic A2F,
   input  logic OE_IN,
   output logic IQZ,
   output logic IQEN,
   output logic BUSY
);

   localparam logic [1:0] TURN_LOAD = turn_load(TURN_CYC);

   generate
      if (PIPE_DEPTH < PIPE_DEPTH_MIN || PIPE_DEPTH > PIPE_DEPTH_MAX) begin : g_bad_depth
         $error("pad_out_reg_cell: PIPE_DEPTH %0d out of range", PIPE_DEPTH);
      end
      if (TURN_CYC < TURN_CYC_MIN || TURN_CYC > TURN_CYC_MAX) begin : g_bad_turn
         $error("pad_out_reg_cell: TURN_CYC %0d out of range", TURN_CYC);
      end
   endgenerate

   logic [PIPE_DEPTH:0] pipe;

   assign pipe[0] = A2F;

   for (genvar i = 0; i < PIPE_DEPTH; i++) begin : g_pipe
      pad_dff u_stage (
         .D   (pipe[i]),
         .Q   (pipe[i+1]),
         .CLK (IQC),
         .RST (QRT),
         .EN  (IQE)
      );
   end

   pad_state_t state_q;
   pad_state_t state_d;
   logic [1:0] cnt_q;
   logic [1:0] cnt_d;
   logic [1:0] st_bits;

   always_ff @(posedge IQC or posedge QRT) begin
      if (QRT) begin
         state_q <= ST_OFF;
         cnt_q   <= 2'd0;
      end else if (IQE) begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_OFF: begin
            if (OE_IN) begin
               if (TURN_CYC > 0) begin
                  state_d = ST_TURN;
                  cnt_d   = TURN_LOAD;
               end else begin
                  state_d = ST_DRIVE;
               end
            end
         end
         ST_DRIVE: begin
            if (!OE_IN) begin
               if (TURN_CYC > 0) begin
                  state_d = ST_TURN;
                  cnt_d   = TURN_LOAD;
               end else begin
                  state_d = ST_OFF;
               end
            end
         end
         ST_TURN: begin
            // Only OE_IN at the terminal count picks the exit; toggles before it are ignored.
            if (cnt_q == 2'd0)
               state_d = OE_IN ? ST_DRIVE : ST_OFF;
            else
               cnt_d = cnt_q - 2'd1;
         end
         default: begin
            state_d = ST_OFF;
            cnt_d   = 2'd0;
         end
      endcase
   end

   // The encoding makes bit 0 the drive flag and bit 1 the busy flag, so both come straight off flops.
   assign st_bits = state_q;

   logic [PIPE_DEPTH-1:0] en_pipe;

   assign en_pipe[0] = st_bits[0];

   for (genvar i = 1; i < PIPE_DEPTH; i++) begin : g_en_dly
      pad_dff u_stage (
         .D   (en_pipe[i-1]),
         .Q   (en_pipe[i]),
         .CLK (IQC),
         .RST (QRT),
         .EN  (IQE)
      );
   end

   generate
      if (OSEL) begin : g_iqz_reg
         assign IQZ = pipe[PIPE_DEPTH];
      end else begin : g_iqz_byp
         assign IQZ = A2F;
      end

      if (ESEL) begin : g_en_reg
         assign IQEN = en_pipe[PIPE_DEPTH-1];
         assign BUSY = st_bits[1];
      end else begin : g_en_byp
         assign IQEN = OE_IN;
         assign BUSY = 1'b0;
      end
   endgenerate

`ifdef PAD_CELL_TIMING
   specify
      specparam t_su = 0, t_hd = 0, t_cq = 0;
      (IQC => IQZ)  = t_cq;
      (IQC => IQEN) = t_cq;
      $setup(A2F,   posedge IQC, t_su);
      $hold(posedge IQC, A2F,   t_hd);
      $setup(OE_IN, posedge IQC, t_su);
      $hold(posedge IQC, OE_IN, t_hd);
      $setup(IQE,   posedge IQC, t_su);
      $hold(posedge IQC, IQE,   t_hd);
      $setup(QRT,   posedge IQC, t_su);
      $hold(posedge IQC, QRT,   t_hd);
   endspecify
`endif

endmodule

// File: tb/tb_pad_out_reg_cell.sv
// Directed bench for pad_out_reg_cell: several parameterisations share one
// set of inputs and are checked against hand-computed vectors.
module tb_pad_out_reg_cell;

   logic clk_sys = 1'b0;
   logic qrt, iqe, a2f, oe_in;

   logic p3_iqz,  p3_iqen,  p3_busy;
   logic t2_iqz,  t2_iqen,  t2_busy;
   logic t3_iqz,  t3_iqen,  t3_busy;
   logic t0_iqz,  t0_iqen,  t0_busy;
   logic byp_iqz, byp_iqen, byp_busy;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk_sys = ~clk_sys;

   pad_out_reg_cell #(.OSEL(1'b1), .ESEL(1'b1), .PIPE_DEPTH(3), .TURN_CYC(1)) u_p3 (
      .IQC(clk_sys), .QRT(qrt), .IQE(iqe), .A2F(a2f), .OE_IN(oe_in),
      .IQZ(p3_iqz), .IQEN(p3_iqen), .BUSY(p3_busy));

   pad_out_reg_cell #(.OSEL(1'b1), .ESEL(1'b1), .PIPE_DEPTH(1), .TURN_CYC(2)) u_t2 (
      .IQC(clk_sys), .QRT(qrt), .IQE(iqe), .A2F(a2f), .OE_IN(oe_in),
      .IQZ(t2_iqz), .IQEN(t2_iqen), .BUSY(t2_busy));

   pad_out_reg_cell #(.OSEL(1'b1), .ESEL(1'b1), .PIPE_DEPTH(1), .TURN_CYC(3)) u_t3 (
      .IQC(clk_sys), .QRT(qrt), .IQE(iqe), .A2F(a2f), .OE_IN(oe_in),
      .IQZ(t3_iqz), .IQEN(t3_iqen), .BUSY(t3_busy));

   pad_out_reg_cell #(.OSEL(1'b1), .ESEL(1'b1), .PIPE_DEPTH(1), .TURN_CYC(0)) u_t0 (
      .IQC(clk_sys), .QRT(qrt), .IQE(iqe), .A2F(a2f), .OE_IN(oe_in),
      .IQZ(t0_iqz), .IQEN(t0_iqen), .BUSY(t0_busy));

   pad_out_reg_cell #(.OSEL(1'b0), .ESEL(1'b0), .PIPE_DEPTH(1), .TURN_CYC(1)) u_byp (
      .IQC(clk_sys), .QRT(qrt), .IQE(iqe), .A2F(a2f), .OE_IN(oe_in),
      .IQZ(byp_iqz), .IQEN(byp_iqen), .BUSY(byp_busy));

   task automatic chk(input string tag, input logic got, input logic exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %b expected %b", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_sys);
      #1;
   endtask

   task automatic do_reset();
      qrt   = 1'b1;
      iqe   = 1'b1;
      a2f   = 1'b0;
      oe_in = 1'b0;
      @(negedge clk_sys);
      qrt   = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bit pat34 [6] = '{1, 0, 1, 1, 0, 0};
      bit exp34 [6] = '{0, 0, 1, 0, 1, 1};

      bit oe35   [7] = '{1, 1, 1, 1, 0, 0, 0};
      bit t2b35  [7] = '{1, 1, 0, 0, 1, 1, 0};
      bit t2e35  [7] = '{0, 0, 1, 1, 0, 0, 0};
      bit p3e35  [7] = '{0, 0, 0, 1, 1, 1, 0};
      bit t3b35  [7] = '{1, 1, 1, 0, 1, 1, 1};
      bit t3e35  [7] = '{0, 0, 0, 1, 0, 0, 0};
      bit t0e35  [7] = '{1, 1, 1, 1, 0, 0, 0};

      bit oe36   [5] = '{1, 1, 0, 0, 0};
      bit t3b36  [5] = '{1, 1, 1, 0, 0};

      bit va38   [4] = '{0, 1, 0, 1};
      bit vo38   [4] = '{0, 0, 1, 1};

      // reset state
      qrt = 1'b1; iqe = 1'b1; a2f = 1'b1; oe_in = 1'b1;
      #1;
      chk("rst_p3_iqz",  p3_iqz,  1'b0);
      chk("rst_p3_iqen", p3_iqen, 1'b0);
      chk("rst_t2_busy", t2_busy, 1'b0);
      chk("rst_t2_iqen", t2_iqen, 1'b0);
      chk("rst_t2_iqz",  t2_iqz,  1'b0);

      // latency through a three-deep pipeline
      do_reset();
      for (int i = 0; i < 6; i++) begin
         a2f = pat34[i];
         tick();
         chk($sformatf("lat_p3_iqz_e%0d", i + 1), p3_iqz, exp34[i]);
      end

      // turnaround windows for TURN_CYC = 0..3 and enable alignment at depth 3
      do_reset();
      for (int i = 0; i < 7; i++) begin
         oe_in = oe35[i];
         tick();
         chk($sformatf("turn_t2_busy_e%0d", i), t2_busy, t2b35[i]);
         chk($sformatf("turn_t2_iqen_e%0d", i), t2_iqen, t2e35[i]);
         chk($sformatf("turn_p3_iqen_e%0d", i), p3_iqen, p3e35[i]);
         chk($sformatf("turn_t3_busy_e%0d", i), t3_busy, t3b35[i]);
         chk($sformatf("turn_t3_iqen_e%0d", i), t3_iqen, t3e35[i]);
         chk($sformatf("turn_t0_iqen_e%0d", i), t0_iqen, t0e35[i]);
         chk($sformatf("turn_t0_busy_e%0d", i), t0_busy, 1'b0);
      end

      // OE_IN dropping inside TURN: counter keeps running, exit goes to OFF
      do_reset();
      for (int i = 0; i < 5; i++) begin
         oe_in = oe36[i];
         tick();
         chk($sformatf("tog_t3_busy_e%0d", i), t3_busy, t3b36[i]);
         chk($sformatf("tog_t3_iqen_e%0d", i), t3_iqen, 1'b0);
      end

      // clock enable low while in TURN with count 1
      do_reset();
      a2f   = 1'b1;
      oe_in = 1'b1;
      tick();
      chk("ce_t2_busy_e0", t2_busy, 1'b1);
      chk("ce_t2_iqz_e0",  t2_iqz,  1'b1);
      iqe = 1'b0;
      a2f = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk($sformatf("ce_hold_busy_%0d", i), t2_busy, 1'b1);
         chk($sformatf("ce_hold_iqen_%0d", i), t2_iqen, 1'b0);
         chk($sformatf("ce_hold_iqz_%0d",  i), t2_iqz,  1'b1);
      end
      iqe = 1'b1;
      tick();
      chk("ce_res1_busy", t2_busy, 1'b1);
      chk("ce_res1_iqen", t2_iqen, 1'b0);
      chk("ce_res1_iqz",  t2_iqz,  1'b0);
      tick();
      chk("ce_res2_busy", t2_busy, 1'b0);
      chk("ce_res2_iqen", t2_iqen, 1'b1);

      // asynchronous reset mid-cycle with the pipeline and enable loaded
      a2f = 1'b1;
      tick(); tick(); tick();
      chk("ar_pre_p3_iqz",  p3_iqz,  1'b1);
      chk("ar_pre_t2_iqen", t2_iqen, 1'b1);
      @(posedge clk_sys);
      #3 qrt = 1'b1;
      #1;
      chk("ar_t2_iqz",  t2_iqz,  1'b0);
      chk("ar_t2_iqen", t2_iqen, 1'b0);
      chk("ar_t2_busy", t2_busy, 1'b0);
      chk("ar_p3_iqz",  p3_iqz,  1'b0);
      chk("ar_p3_iqen", p3_iqen, 1'b0);
      #2 qrt = 1'b0;
      tick();
      chk("ar_first_t2_busy", t2_busy, 1'b1);
      chk("ar_first_p3_iqz",  p3_iqz,  1'b0);
      chk("ar_first_t0_iqen", t0_iqen, 1'b1);
      tick(); tick();
      chk("ar_refill_p3_iqz", p3_iqz, 1'b1);

      // combinational bypass
      for (int i = 0; i < 4; i++) begin
         a2f   = va38[i];
         oe_in = vo38[i];
         #1;
         chk($sformatf("byp_iqz_%0d",  i), byp_iqz,  va38[i]);
         chk($sformatf("byp_iqen_%0d", i), byp_iqen, vo38[i]);
         chk($sformatf("byp_busy_%0d", i), byp_busy, 1'b0);
         tick();
         chk($sformatf("byp_busy_clk_%0d", i), byp_busy, 1'b0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/pad_out_reg_cell.md
PAD_OUT_REG_CELL -- requirements
Module: pad_out_reg_cell

Interface
REQ-001 Parameter OSEL, default 1: 1 = pad data taken from the data pipeline, 0 = combinational bypass of A2F.
REQ-002 Parameter ESEL, default 1: 1 = pad enable taken from the turnaround state machine, 0 = combinational bypass of OE_IN.
REQ-003 Parameter PIPE_DEPTH, default 1, legal 1..3: number of data register stages between A2F and IQZ.
REQ-004 Parameter TURN_CYC, default 1, legal 0..3: number of forced high-Z cycles on every OE transition.
REQ-005 IQC  input  1  clock, rising edge, clkbuf sink; the cell has only this clock.
REQ-006 QRT  input  1  reset, asynchronous, active-high.
REQ-007 IQE  input  1  clock enable; when low, all registers and the state machine hold.
REQ-008 A2F  input  1  data from the fabric, destined for the pad.
REQ-009 OE_IN  input  1  requested pad drive enable from the fabric.
REQ-010 IQZ  output  1  data to the pad driver.
REQ-011 IQEN  output  1  pad driver enable, 1 = drive.
REQ-012 BUSY  output  1  high while a turnaround is in progress.

Function
REQ-013 Data pipeline: when IQE is high, each rising IQC edge shifts A2F through PIPE_DEPTH flops; IQZ equals the last stage when OSEL=1.
REQ-014 Latency (OSEL=1): IQZ reflects A2F sampled PIPE_DEPTH enabled edges earlier; with OSEL=0, IQZ follows A2F combinationally.
REQ-015 The state machine has three states: OFF (IQEN=0), DRIVE (IQEN=1), TURN (IQEN=0, BUSY=1).
REQ-016 In OFF, on an enabled edge with OE_IN=1: go to TURN if TURN_CYC>0, otherwise go to DRIVE.
REQ-017 In DRIVE, on an enabled edge with OE_IN=0: go to TURN if TURN_CYC>0, otherwise go to OFF.
REQ-018 The turnaround counter (2 bits) loads TURN_CYC-1 on entry to TURN and decrements on each enabled edge.
REQ-019 At count 0, TURN exits to DRIVE if the OE_IN sampled on that edge is 1, otherwise to OFF.
REQ-020 OE_IN toggling during TURN does not restart the counter; only the OE_IN value at exit decides the target state.
REQ-021 OE_IN held constant for a full TURN_CYC window produces exactly TURN_CYC cycles of IQEN=0.
REQ-022 The enable path has the same latency as the data path: IQEN in DRIVE is delayed by PIPE_DEPTH-1 extra stages so data and enable align at the pad.
REQ-023 IQE low freezes the state, counter and pipeline; BUSY and IQEN keep their current values.
REQ-024 With ESEL=0, IQEN=OE_IN combinationally, BUSY=0 and the state machine is unused.
REQ-025 Outputs are glitch-free: IQZ, IQEN and BUSY come directly from flops whenever OSEL=1 and ESEL=1.

Reset
REQ-026 QRT high immediately forces IQZ=0, IQEN=0, BUSY=0, state=OFF, counter=0 and all pipeline stages=0, independent of IQC.
REQ-027 After QRT deasserts, the first enabled edge is evaluated normally; no cycles are lost.
REQ-028 Reset asserted mid-TURN or mid-pipeline discards the in-flight data and the turnaround without completing them.

Structure
REQ-029 A shared package pad_reg_pkg holds the state encoding (OFF=2'b00, DRIVE=2'b01, TURN=2'b10) and the PIPE_DEPTH and TURN_CYC legal-range constants.
REQ-030 The flop primitive is one sub-module, pad_dff (D, Q, CLK, RST, EN), instantiated for every pipeline stage and enable-delay stage.
REQ-031 The cell carries whitebox and FASM_PARAMS attributes; its specify block gives setup/hold for A2F, OE_IN, IQE and QRT against posedge IQC, plus IQC->IQZ and IQC->IQEN clock-to-Q.
REQ-032 The elaboration check rejects out-of-range PIPE_DEPTH or TURN_CYC values.

Verification
REQ-033 Reset: QRT pulse mid-cycle with A2F=1 and OE_IN=1 -> IQZ=0, IQEN=0 and BUSY=0 before the next IQC edge.
REQ-034 Latency: PIPE_DEPTH=3, A2F pattern 1,0,1,1 -> IQZ shows 1,0,1,1 starting on the third enabled edge.
REQ-035 Turnaround on: TURN_CYC=2, OE_IN 0->1 held -> BUSY=1 for 2 cycles, then IQEN=1; OE_IN 1->0 -> BUSY=1 for 2 cycles, then OFF.
REQ-036 Toggle during TURN: TURN_CYC=3, OE_IN 0->1 then back to 0 in the second TURN cycle -> exit to OFF after 3 cycles, IQEN never asserts.
REQ-037 Clock enable: IQE=0 for 4 cycles in TURN with count=1 -> state, BUSY and IQZ frozen; resumes and exits on the second enabled edge after IQE returns high.
REQ-038 Bypass: OSEL=0, ESEL=0 -> IQZ==A2F and IQEN==OE_IN within the same cycle, BUSY=0 throughout.
